// File: rtl/pratica_pkg.sv
// ----------------------------------------------------------------------------
// pratica_pkg
//   Shared types and constants for the pratica 3-input LUT block.
//   - sel_t              : 3-bit LUT index, packed as {a,b,c} (a is the MSB).
//   - PRATICA_TT_DEFAULT : default truth table, y = (~b & ~c) | (a & ~b).
//                          Minterms 000, 100 and 101 give 8'h31.
//   - sel_onehot()       : one-hot decode of an index, used by coverage logic.
// ----------------------------------------------------------------------------
package pratica_pkg;

    typedef logic [2:0] sel_t;

    localparam logic [7:0] PRATICA_TT_DEFAULT = 8'h31;

    // An X/Z index yields an X vector, so unknown inputs are not silently
    // recorded as coverage.
    function automatic logic [7:0] sel_onehot(input sel_t sel);
        return 8'h01 << sel;
    endfunction

endpackage

// File: rtl/pratica_if.sv
// ----------------------------------------------------------------------------
// pratica_if
//   Bundle of the pratica function and status signals.
//   - master : the side that drives a, b, c and observes the results.
//   - slave  : the pratica side, which consumes a, b, c and produces
//              y, y_q, cov_seen and cov_full.
//   clk and reset are plain scalar ports of pratica, not part of the bundle.
// ----------------------------------------------------------------------------
interface pratica_if;

    logic       a;
    logic       b;
    logic       c;
    logic       y;
    logic       y_q;
    logic [7:0] cov_seen;
    logic       cov_full;

    modport master (
        output a, b, c,
        input  y, y_q, cov_seen, cov_full
    );

    modport slave (
        input  a, b, c,
        output y, y_q, cov_seen, cov_full
    );

endinterface

// File: rtl/pratica_lut3.sv
// ----------------------------------------------------------------------------
// pratica_lut3
//   Purely combinational 3-input lookup table: y = TT[sel].
//   Ports:
//     sel  in   3  LUT index {a,b,c}
//     y    out  1  table output
//   An unknown index reads back X, so X/Z on any input propagates to y.
// ----------------------------------------------------------------------------
module pratica_lut3
    import pratica_pkg::*;
#(
    parameter logic [7:0] TT = PRATICA_TT_DEFAULT
) (
    input  sel_t sel,
    output logic y
);

    assign y = TT[sel];

endmodule

// File: rtl/pratica.sv
// ----------------------------------------------------------------------------
// pratica
//   3-input Boolean function block built on an 8-entry truth table, plus a
//   registered copy of the output and sticky input-coverage status.
//   Ports (in declaration order, so a positional a/b/c/y instance binds):
//     a         in   1  function input, MSB of the index
//     b         in   1  function input
//     c         in   1  function input, LSB of the index
//     y         out  1  combinational output, TT[{a,b,c}]
//     clk       in   1  rising-edge clock
//     reset     in   1  asynchronous, active-high reset
//     y_q       out  1  y captured on each rising clk
//     cov_seen  out  8  sticky bit per index {a,b,c} seen at a clk edge
//     cov_full  out  1  set once every index has been seen; sticky
//   Parameters:
//     TT      truth table, bit index = {a,b,c}
//     REG_EN  1 builds y_q and coverage; 0 ties them to zero
// ----------------------------------------------------------------------------
module pratica
    import pratica_pkg::*;
#(
    parameter logic [7:0] TT     = PRATICA_TT_DEFAULT,
    parameter bit         REG_EN = 1'b1
) (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       y,
    input  logic       clk,
    input  logic       reset,
    output logic       y_q,
    output logic [7:0] cov_seen,
    output logic       cov_full
);

    sel_t sel;

    assign sel = {a, b, c};

    // Single LUT instance: drives y directly and feeds the y_q register.
    pratica_lut3 #(
        .TT (TT)
    ) u_lut (
        .sel (sel),
        .y   (y)
    );

    if (REG_EN) begin : g_reg

        logic [7:0] cov_next;

        // cov_full is derived from the same next-state vector as cov_seen, so
        // it rises on the very edge that records the last missing index.
        assign cov_next = cov_seen | sel_onehot(sel);

        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                y_q      <= 1'b0;
                cov_seen <= 8'h00;
                cov_full <= 1'b0;
            end else begin
                y_q      <= y;
                cov_seen <= cov_next;
                cov_full <= &cov_next;
            end
        end

    end else begin : g_noreg

        assign y_q      = 1'b0;
        assign cov_seen = 8'h00;
        assign cov_full = 1'b0;

    end

endmodule

// File: tb/tb_pratica.sv
// ----------------------------------------------------------------------------
// tb_pratica
//   Self-checking bench for pratica. Expected values come from the Boolean
//   equation y = (~b & ~c) | (a & ~b) and from a small model of "which
//   indices have been seen since the last reset".
// ----------------------------------------------------------------------------
module tb_pratica;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    pratica_if bus ();

    pratica dut (
        .a        (bus.a),
        .b        (bus.b),
        .c        (bus.c),
        .y        (bus.y),
        .clk      (clk),
        .reset    (reset),
        .y_q      (bus.y_q),
        .cov_seen (bus.cov_seen),
        .cov_full (bus.cov_full)
    );

    // Positional instance sharing the same inputs. Its clock is held idle
    // and its reset held asserted, so only the combinational y is live.
    logic       p_y;
    logic       p_y_q;
    logic [7:0] p_cov_seen;
    logic       p_cov_full;

    pratica u_pos (bus.a, bus.b, bus.c, p_y, 1'b0, 1'b1, p_y_q, p_cov_seen, p_cov_full);

    // Reference model state.
    bit   seen [8];
    logic exp_y_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic ref_y(input logic [2:0] s);
        logic a, b, c;
        {a, b, c} = s;
        return (~b & ~c) | (a & ~b);
    endfunction

    function automatic logic [7:0] ref_cov();
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = seen[i];
        return v;
    endfunction

    function automatic logic ref_full();
        for (int i = 0; i < 8; i++) if (!seen[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [2:0] s);
        {bus.a, bus.b, bus.c} = s;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        exp_y_q = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".y_q"},      {7'h0, bus.y_q},    {7'h0, exp_y_q});
        check({tag, ".cov_seen"}, bus.cov_seen,       ref_cov());
        check({tag, ".cov_full"}, {7'h0, bus.cov_full}, {7'h0, ref_full()});
    endtask

    // One clock cycle: drive at the falling edge, check y shortly after,
    // then check the registered outputs 1 time unit after the rising edge.
    task automatic cycle(input logic [2:0] s, input string tag);
        @(negedge clk);
        drive(s);
        #4;
        check({tag, ".y"},     {7'h0, bus.y}, {7'h0, ref_y(s)});
        check({tag, ".y_pos"}, {7'h0, p_y},   {7'h0, ref_y(s)});
        @(posedge clk);
        seen[s] = 1'b1;
        exp_y_q = ref_y(s);
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [2:0] s;

        tests_run    = 0;
        tests_failed = 0;
        model_reset();

        // Reset held for 27 time units across the edges at t=5, 15, 25.
        reset = 1'b1;
        drive(3'b000);
        #1;
        check_regs("reset_init");
        repeat (9) begin
            s = 3'($urandom_range(0, 7));
            drive(s);
            #2;
            check("reset_hold.y",        {7'h0, bus.y}, {7'h0, ref_y(s)});
            check("reset_hold.y_q",      {7'h0, bus.y_q}, 8'h00);
            check("reset_hold.cov_seen", bus.cov_seen,  8'h00);
            #1;
        end
        reset = 1'b0;

        // Coverage walk 000..111, one index per cycle; also exhaustive y.
        for (int i = 0; i < 8; i++) begin
            cycle(3'(i), "walk");
        end
        check("walk.full_after_8", {7'h0, bus.cov_full}, 8'h01);
        check("walk.all_seen",     bus.cov_seen,         8'hFF);

        // Registered path: 100 then 110.
        cycle(3'b100, "regpath_100");
        check("regpath_100.y_q_is_1", {7'h0, bus.y_q}, 8'h01);
        cycle(3'b110, "regpath_110");
        check("regpath_110.y_q_is_0", {7'h0, bus.y_q}, 8'h00);

        // Repeated random values must not clear any coverage bit.
        repeat (20) cycle(3'($urandom_range(0, 7)), "repeat");

        // Asynchronous reset between edges clears state before the next edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_regs("async_reset");
        @(posedge clk);
        #1;
        check_regs("async_reset_hold");
        #2;
        reset = 1'b0;

        // Random operation from a cleared state; coverage builds up again.
        repeat (30) cycle(3'($urandom_range(0, 7)), "random");

        // The positional instance never leaves reset.
        check("pos.y_q",      {7'h0, p_y_q},      8'h00);
        check("pos.cov_seen", p_cov_seen,         8'h00);
        check("pos.cov_full", {7'h0, p_cov_full}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
